// File: rtl/dot_driver.sv
// dot_driver: scans an 8x8 LED matrix from a double-buffered frame store, blanking after every row change.
// Latency: outputs registered; a new row lights BLANK_CYCLES+1 edges after the edge that samples the change.
// Backpressure: none; writes are accepted every cycle and a swap request is held until the next 7->0 wrap.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   row_idx[2:0]          current scan row from the scan counter
//   wr_en/wr_addr/wr_data back-buffer row write (bit k = column k, 1 = lit)
//   swap_req              request a front/back swap at the next frame boundary
//   swap_pending          a swap is requested but not yet performed
//   frame_tick            one-cycle pulse on each 7->0 row wrap
//   row_out/col_out       one-hot row drive and column drive, both 0 while blanked
module dot_driver #(
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] row_idx,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic       frame_tick,
    output logic [7:0] row_out,
    output logic [7:0] col_out
);

    localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYCLES);

    logic [2:0] r_row;
    logic [3:0] r_blank_cnt;
    logic       r_front_sel;
    logic [7:0] r_buf0 [8];
    logic [7:0] r_buf1 [8];
    logic       r_swap_pending;
    logic       r_frame_tick;
    logic [7:0] r_row_out;
    logic [7:0] r_col_out;

    logic       w_chg;
    logic       w_fb;
    logic       w_do_swap;
    logic [7:0] w_front_row;

    assign w_chg       = (row_idx != r_row);
    // Only a genuine 7 -> 0 wrap marks a frame boundary; other jumps are plain row changes.
    assign w_fb        = w_chg && (r_row == 3'd7) && (row_idx == 3'd0);
    assign w_do_swap   = w_fb && (r_swap_pending || swap_req);
    assign w_front_row = r_front_sel ? r_buf1[r_row] : r_buf0[r_row];

    // Scan, blanking and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= 3'd0;
            r_blank_cnt <= BLANK_INIT;
            r_row_out   <= 8'd0;
            r_col_out   <= 8'd0;
        end else if (w_chg) begin
            // Any change, including one mid-blanking, restarts the gap.
            r_row       <= row_idx;
            r_blank_cnt <= BLANK_INIT;
            r_row_out   <= 8'd0;
            r_col_out   <= 8'd0;
        end else if (r_blank_cnt != 4'd0) begin
            r_blank_cnt <= r_blank_cnt - 4'd1;
            r_row_out   <= 8'd0;
            r_col_out   <= 8'd0;
        end else begin
            r_row_out   <= 8'd1 << r_row;
            r_col_out   <= w_front_row;
        end
    end

    // Buffer select, swap handshake and frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front_sel    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_frame_tick   <= 1'b0;
        end else begin
            r_frame_tick <= w_fb;
            if (w_do_swap) begin
                r_front_sel    <= ~r_front_sel;
                r_swap_pending <= 1'b0;
            end else if (swap_req) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    // Frame store. The write target uses the pre-edge select, so a write on the
    // swap edge lands in the buffer that becomes the new front.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_buf0[i] <= 8'd0;
                r_buf1[i] <= 8'd0;
            end
        end else if (wr_en) begin
            if (r_front_sel) begin
                r_buf0[wr_addr] <= wr_data;
            end else begin
                r_buf1[wr_addr] <= wr_data;
            end
        end
    end

    assign swap_pending = r_swap_pending;
    assign frame_tick   = r_frame_tick;
    assign row_out      = r_row_out;
    assign col_out      = r_col_out;

endmodule

// File: tb/tb_dot_driver.sv
// tb_dot_driver: drives dot_driver with directed and random scan/write/swap traffic.
// Latency: expected outputs come from a frame-image reference model updated at every rising edge.
// Backpressure: not applicable; every cycle is compared.
module tb_dot_driver;

    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] row_idx = 3'd0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic       swap_req = 1'b0;
    logic       swap_pending;
    logic       frame_tick;
    logic [7:0] row_out;
    logic [7:0] col_out;

    always #5 clk = ~clk;

    dot_driver #(.BLANK_CYCLES(BC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .row_idx      (row_idx),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .frame_tick   (frame_tick),
        .row_out      (row_out),
        .col_out      (col_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: displayed and hidden frame images, the last row seen,
    // the number of edges the row has been stable, and the pending-swap flag.
    int         since;
    logic [2:0] m_row;
    logic [7:0] m_front [8];
    logic [7:0] m_back  [8];
    logic       m_pend;
    logic [7:0] e_row, e_col;
    logic       e_ft, e_sp;

    task automatic model_reset();
        since = 0;
        m_row = 3'd0;
        for (int i = 0; i < 8; i++) begin
            m_front[i] = 8'd0;
            m_back[i]  = 8'd0;
        end
        m_pend = 1'b0;
        e_row = 8'd0; e_col = 8'd0; e_ft = 1'b0; e_sp = 1'b0;
    endtask

    // Advance one clock: update the model with the inputs present at the edge,
    // then move 1 time unit past the edge so outputs can be sampled.
    task automatic tick();
        logic       chg, fb;
        logic [7:0] tmp;
        @(posedge clk);
        chg = (row_idx != m_row);
        fb  = chg && (m_row == 3'd7) && (row_idx == 3'd0);
        e_row = 8'd0;
        e_col = 8'd0;
        if (chg) begin
            since = 0;
        end else begin
            if (since < 1000) since++;
            if (since > BC) begin
                e_row = 8'd1 << m_row;
                e_col = m_front[m_row];
            end
        end
        e_ft = fb;
        if (wr_en) m_back[wr_addr] = wr_data;
        if (fb && (m_pend || swap_req)) begin
            for (int i = 0; i < 8; i++) begin
                tmp = m_front[i];
                m_front[i] = m_back[i];
                m_back[i]  = tmp;
            end
            m_pend = 1'b0;
        end else if (swap_req) begin
            m_pend = 1'b1;
        end
        e_sp = m_pend;
        if (chg) m_row = row_idx;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({row_out, col_out, frame_tick, swap_pending} !== 18'h0) begin
            n_errors++;
            $display("FAIL reset_hold got row=%h col=%h ft=%b sp=%b need all 0",
                     row_out, col_out, frame_tick, swap_pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                n_errors++;
                $display("FAIL reset_model edge%0d got %h/%h/%b/%b need %h/%h/%b/%b", k,
                         row_out, col_out, frame_tick, swap_pending, e_row, e_col, e_ft, e_sp);
            end
            n_checks++;
            if (k <= BC && {row_out, col_out} !== 16'h0000) begin
                n_errors++;
                $display("FAIL reset_blank edge%0d got row=%h col=%h need 00/00", k, row_out, col_out);
            end else if (k == BC + 1 && {row_out, col_out} !== 16'h0100) begin
                n_errors++;
                $display("FAIL reset_first_row edge%0d got row=%h col=%h need 01/00", k, row_out, col_out);
            end
        end
    endtask

    task automatic test_swap_frame();
        int ft_cnt;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'hA0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        n_checks++;
        if (swap_pending !== 1'b1) begin
            n_errors++;
            $display("FAIL swap_pending_rise got %b need 1", swap_pending);
        end
        for (int r = 1; r < 8; r++) begin
            row_idx = 3'(r);
            for (int k = 0; k < 10; k++) begin
                tick();
                n_checks++;
                if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                    n_errors++;
                    $display("FAIL frame_model row%0d got %h/%h/%b/%b need %h/%h/%b/%b", r,
                             row_out, col_out, frame_tick, swap_pending, e_row, e_col, e_ft, e_sp);
                end
                n_checks++;
                if (col_out !== 8'h00) begin
                    n_errors++;
                    $display("FAIL prewrap_col row%0d got %h need 00", r, col_out);
                end
            end
        end
        ft_cnt = 0;
        row_idx = 3'd0;
        tick();
        n_checks++;
        if (frame_tick !== 1'b1 || swap_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_edge got ft=%b sp=%b need ft=1 sp=0", frame_tick, swap_pending);
        end
        for (int r = 0; r < 4; r++) begin
            row_idx = 3'(r);
            for (int k = 0; k < 10; k++) begin
                if (!(r == 0 && k == 0)) tick();
                if (frame_tick === 1'b1) ft_cnt++;
                n_checks++;
                if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                    n_errors++;
                    $display("FAIL newframe_model row%0d got %h/%h/%b/%b need %h/%h/%b/%b", r,
                             row_out, col_out, frame_tick, swap_pending, e_row, e_col, e_ft, e_sp);
                end
            end
        end
        n_checks++;
        if (row_out !== 8'h08 || col_out !== 8'hA3) begin
            n_errors++;
            $display("FAIL swapped_row3 got row=%h col=%h need 08/A3", row_out, col_out);
        end
        n_checks++;
        if (ft_cnt != 1) begin
            n_errors++;
            $display("FAIL frame_tick_count got %0d need 1", ft_cnt);
        end
    endtask

    task automatic test_blank_gap();
        int zeros;
        bit lit;
        row_idx = 3'd2;
        repeat (10) tick();
        row_idx = 3'd3;
        zeros = 0; lit = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (!lit && row_out === 8'h00) zeros++;
            else lit = 1;
            n_checks++;
            if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                n_errors++;
                $display("FAIL gap_model k%0d got %h/%h need %h/%h", k, row_out, col_out, e_row, e_col);
            end
        end
        n_checks++;
        if (zeros != BC + 1 || row_out !== 8'h08) begin
            n_errors++;
            $display("FAIL gap_2to3 got zeros=%0d row=%h need zeros=%0d row=08", zeros, row_out, BC + 1);
        end
        row_idx = 3'd4;
        tick();
        row_idx = 3'd5;
        zeros = 0; lit = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (!lit && row_out === 8'h00) zeros++;
            else lit = 1;
            n_checks++;
            if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                n_errors++;
                $display("FAIL regap_model k%0d got %h/%h need %h/%h", k, row_out, col_out, e_row, e_col);
            end
        end
        n_checks++;
        if (zeros != BC + 1 || row_out !== 8'h20 || col_out !== 8'hA5) begin
            n_errors++;
            $display("FAIL gap_restart got zeros=%0d row=%h col=%h need zeros=%0d 20/A5",
                     zeros, row_out, col_out, BC + 1);
        end
    endtask

    task automatic test_swap_coincident();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'h10 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int r = 6; r < 8; r++) begin
            row_idx = 3'(r);
            repeat (5) tick();
        end
        row_idx = 3'd0;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        n_checks++;
        if (frame_tick !== 1'b1 || swap_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL coincident_edge got ft=%b sp=%b need ft=1 sp=0", frame_tick, swap_pending);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                n_errors++;
                $display("FAIL coincident_model k%0d got %h/%h/%b/%b need %h/%h/%b/%b", k,
                         row_out, col_out, frame_tick, swap_pending, e_row, e_col, e_ft, e_sp);
            end
        end
        n_checks++;
        if (col_out !== 8'h10 || swap_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL coincident_front got col=%h sp=%b need col=10 sp=0", col_out, swap_pending);
        end
        // Two requests in one frame must produce exactly one toggle.
        for (int r = 1; r < 8; r++) begin
            row_idx = 3'(r);
            swap_req = (r == 2 || r == 4);
            for (int k = 0; k < 5; k++) begin
                tick();
                swap_req = 1'b0;
                n_checks++;
                if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                    n_errors++;
                    $display("FAIL dblreq_model row%0d got %h/%h/%b/%b need %h/%h/%b/%b", r,
                             row_out, col_out, frame_tick, swap_pending, e_row, e_col, e_ft, e_sp);
                end
            end
        end
        n_checks++;
        if (swap_pending !== 1'b1) begin
            n_errors++;
            $display("FAIL dblreq_pending got %b need 1", swap_pending);
        end
        for (int r = 0; r < 4; r++) begin
            row_idx = 3'(r);
            repeat (5) tick();
        end
        n_checks++;
        if (row_out !== 8'h08 || col_out !== 8'hA3 || swap_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL dblreq_single_toggle got row=%h col=%h sp=%b need 08/A3 sp=0",
                     row_out, col_out, swap_pending);
        end
    endtask

    task automatic test_write_on_swap();
        for (int r = 4; r < 8; r++) begin
            row_idx = 3'(r);
            swap_req = (r == 5);
            for (int k = 0; k < 5; k++) begin
                tick();
                swap_req = 1'b0;
            end
        end
        row_idx = 3'd0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (frame_tick !== 1'b1) begin
            n_errors++;
            $display("FAIL wrswap_edge got ft=%b need 1", frame_tick);
        end
        repeat (4) tick();
        row_idx = 3'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                n_errors++;
                $display("FAIL wrswap_model k%0d got %h/%h need %h/%h", k, row_out, col_out, e_row, e_col);
            end
        end
        n_checks++;
        if (row_out !== 8'h02 || col_out !== 8'h5A) begin
            n_errors++;
            $display("FAIL wrswap_row1 got row=%h col=%h need 02/5A", row_out, col_out);
        end
    endtask

    task automatic test_random();
        int hold;
        logic [2:0] r;
        hold = 0;
        r = row_idx;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 9) < 7) r = r + 3'd1;
                else r = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 8);
            end
            hold--;
            row_idx  = r;
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            swap_req = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++;
            if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                n_errors++;
                $display("FAIL random_model n%0d got %h/%h/%b/%b need %h/%h/%b/%b", n,
                         row_out, col_out, frame_tick, swap_pending, e_row, e_col, e_ft, e_sp);
            end
        end
        wr_en = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        repeat (6) tick();
        n_checks++;
        if (row_out !== e_row || col_out !== e_col || e_row == 8'h00) begin
            n_errors++;
            $display("FAIL premid_lit got row=%h col=%h need %h/%h (lit)", row_out, col_out, e_row, e_col);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({row_out, col_out, frame_tick, swap_pending} !== 18'h0) begin
            n_errors++;
            $display("FAIL async_reset got row=%h col=%h ft=%b sp=%b need all 0",
                     row_out, col_out, frame_tick, swap_pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int r = 0; r < 9; r++) begin
            row_idx = 3'(r % 8);
            for (int k = 0; k < 5; k++) begin
                tick();
                n_checks++;
                if ({row_out, col_out, frame_tick, swap_pending} !== {e_row, e_col, e_ft, e_sp}) begin
                    n_errors++;
                    $display("FAIL postreset_model row%0d got %h/%h need %h/%h", r, row_out, col_out, e_row, e_col);
                end
                n_checks++;
                if (col_out !== 8'h00) begin
                    n_errors++;
                    $display("FAIL postreset_col row%0d got %h need 00", r, col_out);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_swap_frame();
        test_blank_gap();
        test_swap_coincident();
        test_write_on_swap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
